// File: rtl/matmul_apb_slave.sv
// Zero-wait-state APB3 completer for the matmul core: control/flag registers, operand row
// forwarding and scratchpad read-back. Optional error response: MATMUL_APB_SLVERR_EN.
module matmul_apb_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int MAX_DIM     = 4,
    parameter int SP_NTARGETS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              psel,
    input  logic                              penable,
    input  logic                              pwrite,
    input  logic [ADDR_WIDTH-1:0]             paddr,
    input  logic [BUS_WIDTH-1:0]              pwdata,
    input  logic [MAX_DIM-1:0]                pstrb,
    output logic [BUS_WIDTH-1:0]              prdata,
    output logic                              pready,
    output logic                              pslverr,
    output logic                              done,
    output logic                              start_o,
    output logic [BUS_WIDTH-1:0]              ctrl_o,
    output logic                              op_we_o,
    output logic                              op_sel_o,
    output logic [$clog2(MAX_DIM)-1:0]        op_row_o,
    output logic [MAX_DIM*DATA_WIDTH-1:0]     op_wdata_o,
    output logic [MAX_DIM-1:0]                op_be_o,
    output logic                              sp_re_o,
    output logic [$clog2(SP_NTARGETS)-1:0]    sp_sel_o,
    output logic [$clog2(MAX_DIM*MAX_DIM)-1:0] sp_idx_o,
    input  logic [BUS_WIDTH-1:0]              sp_rdata_i,
    input  logic                              core_done_i
);
    localparam int ROW_W = $clog2(MAX_DIM);
    localparam int IDX_W = $clog2(MAX_DIM*MAX_DIM);
    localparam int SEL_W = $clog2(SP_NTARGETS);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
    typedef enum logic [2:0] {R_CTRL, R_A, R_B, R_FLAGS, R_SP, R_ILL} region_e;

    state_e               state_q, state_d;
    region_e              region_s;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_q, start_d;
    logic [BUS_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [BUS_WIDTH-1:0] prdata_q, prdata_d;
    logic                 access_s, wr_s, rd_s;
    logic                 unused_s;

    assign unused_s = ^paddr[ADDR_WIDTH-1:9];

    // Region decode from the low address bits
    always_comb begin
        region_s = R_ILL;
        case (paddr[4:0])
            5'd0:                       region_s = R_CTRL;
            5'd4:                       region_s = R_A;
            5'd8:                       region_s = R_B;
            5'd12:                      region_s = R_FLAGS;
            5'd16, 5'd20, 5'd24, 5'd28: region_s = R_SP;
            default:                    region_s = R_ILL;
        endcase
    end

    // Bus phase tracker; a transfer is only honoured after a genuine SETUP cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (psel && !penable) ? SETUP : IDLE;
            SETUP: begin
                if (psel && penable) begin
                    state_d = ACCESS;
                end else if (psel) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = (psel && !penable) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign access_s = (state_q == SETUP) && psel && penable && !rst;
    assign wr_s     = access_s && pwrite;
    assign rd_s     = access_s && !pwrite;

    assign op_we_o    = wr_s && !busy_q && ((region_s == R_A) || (region_s == R_B));
    assign op_sel_o   = (region_s == R_B);
    assign op_row_o   = paddr[5 +: ROW_W];
    assign op_wdata_o = pwdata;
    assign op_be_o    = pstrb;
    assign sp_re_o    = !rst && psel && !penable && !pwrite && (region_s == R_SP);
    assign sp_sel_o   = paddr[2 +: SEL_W];
    assign sp_idx_o   = paddr[5 +: IDX_W];

    // Register updates; an accepted start overrides a stray completion pulse while idle
    always_comb begin
        busy_d   = busy_q;
        done_d   = done_q;
        start_d  = 1'b0;
        ctrl_d   = ctrl_q;
        prdata_d = prdata_q;
        if (core_done_i) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end else begin
            busy_d = busy_q;
        end
        if (wr_s && (region_s == R_CTRL) && !busy_q) begin
            ctrl_d = {pwdata[BUS_WIDTH-1:1], 1'b0};
            if (pwdata[0]) begin
                start_d = 1'b1;
                busy_d  = 1'b1;
                done_d  = 1'b0;
            end else begin
                start_d = 1'b0;
            end
        end else begin
            ctrl_d = ctrl_q;
        end
        if (rd_s) begin
            case (region_s)
                R_CTRL:  prdata_d = ctrl_q;
                R_FLAGS: prdata_d = {{(BUS_WIDTH-2){1'b0}}, busy_q, done_q};
                R_SP:    prdata_d = sp_rdata_i;
                default: prdata_d = {BUS_WIDTH{1'b0}};
            endcase
        end else begin
            prdata_d = prdata_q;
        end
    end

`ifdef MATMUL_APB_SLVERR_EN
    logic err_s;

    // Error classification of the current transfer
    always_comb begin
        err_s = 1'b0;
        case (region_s)
            R_CTRL:  err_s = pwrite && busy_q;
            R_A,
            R_B:     err_s = !pwrite || busy_q;
            R_FLAGS,
            R_SP:    err_s = pwrite;
            default: err_s = 1'b1;
        endcase
    end

    assign pslverr = access_s && err_s;
`else
    assign pslverr = 1'b0;
`endif

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            ctrl_q   <= {BUS_WIDTH{1'b0}};
            prdata_q <= {BUS_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            start_q  <= start_d;
            ctrl_q   <= ctrl_d;
            prdata_q <= prdata_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = 1'b1;
    assign done    = done_q;
    assign start_o = start_q;
    assign ctrl_o  = ctrl_q;
endmodule

// File: tb/tb_matmul_apb_slave.sv
// Scoreboard bench for matmul_apb_slave: read data and operand strobes are predicted into
// queues and compared as the DUT produces them.
module tb_matmul_apb_slave;
`ifdef MATMUL_APB_SLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, psel, penable, pwrite, core_done_i;
    logic [15:0] paddr;
    logic [31:0] pwdata, sp_rdata_i;
    logic [3:0]  pstrb;
    logic [31:0] prdata, ctrl_o, op_wdata_o;
    logic        pready, pslverr, done, start_o, op_we_o, op_sel_o, sp_re_o;
    logic [1:0]  op_row_o, sp_sel_o;
    logic [3:0]  op_be_o, sp_idx_o;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    logic [31:0] rd_q[$];
    logic [38:0] op_q[$];

    matmul_apb_slave dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .done(done), .start_o(start_o),
        .ctrl_o(ctrl_o), .op_we_o(op_we_o), .op_sel_o(op_sel_o), .op_row_o(op_row_o),
        .op_wdata_o(op_wdata_o), .op_be_o(op_be_o), .sp_re_o(sp_re_o),
        .sp_sel_o(sp_sel_o), .sp_idx_o(sp_idx_o), .sp_rdata_i(sp_rdata_i),
        .core_done_i(core_done_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Operand strobe monitor and start pulse counter
    always @(negedge clk) begin
        if (op_we_o) begin
            if (op_q.size() == 0) check("op_we_unexpected", 64'd1, 64'd0);
            else check("op_we", {op_sel_o, op_row_o, op_wdata_o, op_be_o}, op_q.pop_front());
        end
        if (start_o) start_cnt++;
    end

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit err, input bit cd);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1; core_done_i = cd;
        @(negedge clk);
        check("pslverr_wr", pslverr, ERR_EN & err);
        check("pready", pready, 1'b1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; core_done_i = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, input logic [31:0] exp, input bit err,
                            input bit is_sp, input logic [1:0] esel, input logic [3:0] eidx);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        check("sp_re", sp_re_o, is_sp);
        if (is_sp) begin
            check("sp_sel", sp_sel_o, esel);
            check("sp_idx", sp_idx_o, eidx);
        end
        rd_q.push_back(exp);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("pslverr_rd", pslverr, ERR_EN & err);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check("prdata", prdata, rd_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0;
        pwdata = 32'h0; pstrb = 4'h0; sp_rdata_i = 32'h0; core_done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_start", start_o, 1'b0);
        check("rst_ctrl", ctrl_o, 32'h0);
        check("rst_op_we", op_we_o, 1'b0);
        check("rst_sp_re", sp_re_o, 1'b0);

        // Operand rows: full strobe, then empty strobe still pulses
        op_q.push_back({1'b0, 2'd2, 32'h04030201, 4'hF});
        apb_write(16'd4 | (16'd2 << 5), 32'h04030201, 4'hF, 1'b0, 1'b0);
        op_q.push_back({1'b1, 2'd1, 32'hA5A5_5A5A, 4'h0});
        apb_write(16'd8 | (16'd1 << 5), 32'hA5A5_5A5A, 4'h0, 1'b0, 1'b0);

        // Start
        apb_write(16'd0, 32'h5, 4'h0, 1'b0, 1'b0);
        check("start_pulse", start_o, 1'b1);
        check("ctrl_o", ctrl_o, 32'h4);
        apb_read(16'd12, 32'h2, 1'b0, 1'b0, 2'd0, 4'd0);
        apb_read(16'd0, 32'h4, 1'b0, 1'b0, 2'd0, 4'd0);

        // Writes while busy are rejected
        apb_write(16'd0, 32'h9, 4'hF, 1'b1, 1'b0);
        apb_write(16'd4, 32'h11223344, 4'hF, 1'b1, 1'b0);
        check("ctrl_busy_hold", ctrl_o, 32'h4);
        check("start_cnt_busy", start_cnt, 1);

        // Completion
        @(posedge clk); #1 core_done_i = 1'b1;
        @(posedge clk); #1 core_done_i = 1'b0;
        check("done_set", done, 1'b1);
        apb_read(16'd12, 32'h1, 1'b0, 1'b0, 2'd0, 4'd0);

        // Scratchpad read and hold
        sp_rdata_i = 32'd37;
        apb_read(16'd20 | (16'd5 << 5), 32'd37, 1'b0, 1'b1, 2'd1, 4'd5);
        sp_rdata_i = 32'd99;
        repeat (2) @(posedge clk);
        #1 check("prdata_hold", prdata, 32'd37);
        sp_rdata_i = 32'hDEAD_BEEF;
        apb_read(16'd28 | (16'd15 << 5), 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd3, 4'd15);

        // New start clears done; start coinciding with completion is rejected
        apb_write(16'd0, 32'h3, 4'h0, 1'b0, 1'b0);
        check("done_clr", done, 1'b0);
        apb_write(16'd0, 32'h1, 4'h0, 1'b1, 1'b1);
        check("done_race", done, 1'b1);
        check("ctrl_race", ctrl_o, 32'h2);
        apb_read(16'd12, 32'h1, 1'b0, 1'b0, 2'd0, 4'd0);
        check("start_cnt_race", start_cnt, 2);

        // Error transfers
        apb_read(16'd6, 32'h0, 1'b1, 1'b0, 2'd0, 4'd0);
        apb_write(16'd12, 32'h3, 4'hF, 1'b1, 1'b0);
        apb_read(16'd4, 32'h0, 1'b1, 1'b0, 2'd0, 4'd0);
        apb_write(16'd16, 32'h3, 4'hF, 1'b1, 1'b0);
        apb_read(16'd12, 32'h1, 1'b0, 1'b0, 2'd0, 4'd0);
        check("start_cnt_err", start_cnt, 2);

        // Reset during SETUP aborts the transfer
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd4; pwdata = 32'h77; pstrb = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; penable = 1'b1;
        @(negedge clk);
        check("rst_mid_op_we", op_we_o, 1'b0);
        check("rst_mid_pslverr", pslverr, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_ctrl", ctrl_o, 32'h0);
        check("rst_mid_prdata", prdata, 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;

        // Recovery after reset
        op_q.push_back({1'b0, 2'd3, 32'hCAFE_F00D, 4'h5});
        apb_write(16'd4 | (16'd3 << 5), 32'hCAFE_F00D, 4'h5, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        check("op_q_drained", op_q.size(), 0);
        check("start_cnt_final", start_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
